// File: rtl/conv_result_writer.sv
// conv_result_writer
// -----------------------------------------------------------------------------
// Receiving end of the convolution filter's output stream. Each input beat
// carries four 8-bit result pixels. Beats are buffered in a small FIFO and then
// serialised into a 32768x8 result SRAM, one byte per cycle, at consecutive
// addresses starting at BASE_ADDR (wrapping modulo 32768). After NUM_PIXELS
// bytes have been written, a one-cycle done pulse is raised.
//
// Optional feature: define CONV_RESULT_CHECKSUM_EN to add a 16-bit checksum
// output holding the running sum (mod 65536) of every byte written this frame.
//
// Ports:
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   start               one-cycle arm pulse, accepted only in IDLE
//   in_valid            beat strobe from the filter
//   in_pixel0..3        result lanes, lane 0 written first
//   sram_en / sram_wen  SRAM enable / write enable (both high on a write)
//   sram_addr[14:0]     SRAM address
//   sram_d[7:0]         SRAM write data
//   busy                high while collecting or draining a frame
//   done                one-cycle pulse after the last byte is written
//   overflow            sticky: a beat was dropped because the FIFO was full
//   checksum[15:0]      (CONV_RESULT_CHECKSUM_EN only) running byte sum
// -----------------------------------------------------------------------------
module conv_result_writer #(
  parameter int NUM_PIXELS = 16384,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel0,
  input  logic [7:0]  in_pixel1,
  input  logic [7:0]  in_pixel2,
  input  logic [7:0]  in_pixel3,
  output logic        sram_en,
  output logic        sram_wen,
  output logic [14:0] sram_addr,
  output logic [7:0]  sram_d,
  output logic        busy,
  output logic        done,
  output logic        overflow
`ifdef CONV_RESULT_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] PIX_C   = 16'(NUM_PIXELS);
  localparam logic [15:0] BEAT_C  = 16'(NUM_PIXELS / 4);
  localparam logic [14:0] BASE_C  = 15'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW:0] count_q, count_d;
  logic        active_q, active_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] beatCnt_q, beatCnt_d;
  logic [15:0] pixCnt_q, pixCnt_d;
  logic        en_q, en_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [31:0] beatIn;
  logic        offer, push, pop, full;
  logic [PW:0] remain;
  logic        issue;
  logic [7:0]  issueByte;

  function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  assign beatIn = {in_pixel3, in_pixel2, in_pixel1, in_pixel0};
  // The entry being serialised stays in the FIFO until its lane 3 is on the
  // SRAM port; it is popped at the end of that cycle, which is what lets a
  // full FIFO still accept a beat in that same cycle.
  assign pop    = active_q && (lane_q == 2'd3);
  assign full   = (count_q == DEPTH_C);
  assign offer  = (state_q == COLLECT) && in_valid;
  assign push   = offer && (!full || pop);
  assign remain = count_q - (PW + 1)'(pop);

  // Serialiser: decides which byte goes onto the SRAM port next cycle. When no
  // entry is waiting, a beat arriving this cycle is forwarded straight to
  // lane 0 so the first byte appears one cycle after acceptance.
  always_comb begin
    active_d  = active_q;
    lane_d    = lane_q;
    issue     = 1'b0;
    issueByte = 8'd0;
    rdPtr_d   = rdPtr_q + PW'(pop);
    wrPtr_d   = wrPtr_q + PW'(push);
    count_d   = remain + (PW + 1)'(push);
    if (active_q && (lane_q != 2'd3)) begin
      lane_d    = lane_q + 2'd1;
      issue     = 1'b1;
      issueByte = laneByte(fifoMem[rdPtr_q], lane_q + 2'd1);
    end else if (remain != '0) begin
      active_d  = 1'b1;
      lane_d    = 2'd0;
      issue     = 1'b1;
      issueByte = fifoMem[rdPtr_d][7:0];
    end else if (push) begin
      active_d  = 1'b1;
      lane_d    = 2'd0;
      issue     = 1'b1;
      issueByte = in_pixel0;
    end else begin
      active_d  = 1'b0;
    end
  end

  // Frame FSM and registered SRAM/status outputs. The address is taken from
  // the pixel count before it increments, so pixel n lands at BASE_ADDR+n.
  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    pixCnt_d  = pixCnt_q + 16'(issue);
    ovf_d     = ovf_q | (offer && !push);
    done_d    = 1'b0;
    en_d      = issue;
    addr_d    = issue ? (BASE_C + pixCnt_q[14:0]) : addr_q;
    data_d    = issue ? issueByte : data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          beatCnt_d = 16'd0;
          pixCnt_d  = 16'd0;
          ovf_d     = 1'b0;
        end
      end
      COLLECT: begin
        if (push) begin
          beatCnt_d = beatCnt_q + 16'd1;
          if (beatCnt_q + 16'd1 == BEAT_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pixCnt_q == PIX_C) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT) || (state_d == DRAIN);
  end

  // FIFO storage carries data only; validity lives in the reset pointers.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr_q] <= beatIn;
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      active_q  <= 1'b0;
      lane_q    <= 2'd0;
      beatCnt_q <= 16'd0;
      pixCnt_q  <= 16'd0;
      en_q      <= 1'b0;
      addr_q    <= 15'd0;
      data_q    <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      active_q  <= active_d;
      lane_q    <= lane_d;
      beatCnt_q <= beatCnt_d;
      pixCnt_q  <= pixCnt_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sram_en   = en_q;
  assign sram_wen  = en_q;
  assign sram_addr = addr_q;
  assign sram_d    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

`ifdef CONV_RESULT_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running byte sum, accumulated as each write is issued.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == IDLE) && start) checksum_d = 16'd0;
    else if (issue) checksum_d = checksum_q + {8'd0, issueByte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= 16'd0;
    else checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_conv_result_writer.sv
// Testbench for conv_result_writer. Three instances share the stimulus:
//   dutA: NUM_PIXELS=8, BASE_ADDR=0      (main frame, drain, resets)
//   dutW: NUM_PIXELS=8, BASE_ADDR=32764  (address wrap)
//   dutB: NUM_PIXELS=32, BASE_ADDR=0     (burst / overflow, frame long enough)
module tb_conv_result_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic inValid = 1'b0;
  logic [7:0] p0 = 8'd0, p1 = 8'd0, p2 = 8'd0, p3 = 8'd0;

  logic enA, wenA, busyA, doneA, ovfA;
  logic enW, wenW, busyW, doneW, ovfW;
  logic enB, wenB, busyB, doneB, ovfB;
  logic [14:0] addrA, addrW, addrB;
  logic [7:0] dA, dW, dB;
`ifdef CONV_RESULT_CHECKSUM_EN
  logic [15:0] ckA, ckW, ckB;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used to check write latency and gaps.
  always @(posedge clk) cyc <= cyc + 1;

  conv_result_writer #(.NUM_PIXELS(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid),
    .in_pixel0(p0), .in_pixel1(p1), .in_pixel2(p2), .in_pixel3(p3),
    .sram_en(enA), .sram_wen(wenA), .sram_addr(addrA), .sram_d(dA),
    .busy(busyA), .done(doneA), .overflow(ovfA)
`ifdef CONV_RESULT_CHECKSUM_EN
    , .checksum(ckA)
`endif
  );

  conv_result_writer #(.NUM_PIXELS(8), .BASE_ADDR(32764), .FIFO_DEPTH(4)) dutW (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid),
    .in_pixel0(p0), .in_pixel1(p1), .in_pixel2(p2), .in_pixel3(p3),
    .sram_en(enW), .sram_wen(wenW), .sram_addr(addrW), .sram_d(dW),
    .busy(busyW), .done(doneW), .overflow(ovfW)
`ifdef CONV_RESULT_CHECKSUM_EN
    , .checksum(ckW)
`endif
  );

  conv_result_writer #(.NUM_PIXELS(32), .BASE_ADDR(0), .FIFO_DEPTH(4)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(inValid),
    .in_pixel0(p0), .in_pixel1(p1), .in_pixel2(p2), .in_pixel3(p3),
    .sram_en(enB), .sram_wen(wenB), .sram_addr(addrB), .sram_d(dB),
    .busy(busyB), .done(doneB), .overflow(ovfB)
`ifdef CONV_RESULT_CHECKSUM_EN
    , .checksum(ckB)
`endif
  );

  // Write logs, sampled on the falling edge away from output updates.
  logic [14:0] logAddrA [512];
  logic [7:0]  logDataA [512];
  int          logCycA [512];
  int nWrA = 0, nDoneA = 0, nBadWenA = 0, lastDoneCycA = 0;
  logic [14:0] logAddrW [512];
  logic [7:0]  logDataW [512];
  int nWrW = 0, nDoneW = 0, nBadWenW = 0;
  logic [7:0]  logDataB [512];
  int          logCycB [512];
  int nWrB = 0, nBadWenB = 0;

  always @(negedge clk) begin
    if (enA) begin
      if (nWrA < 512) begin
        logAddrA[nWrA] <= addrA;
        logDataA[nWrA] <= dA;
        logCycA[nWrA]  <= cyc;
      end
      if (!wenA) nBadWenA <= nBadWenA + 1;
      nWrA <= nWrA + 1;
    end
    if (doneA) begin
      nDoneA <= nDoneA + 1;
      lastDoneCycA <= cyc;
    end
    if (enW) begin
      if (nWrW < 512) begin
        logAddrW[nWrW] <= addrW;
        logDataW[nWrW] <= dW;
      end
      if (!wenW) nBadWenW <= nBadWenW + 1;
      nWrW <= nWrW + 1;
    end
    if (doneW) nDoneW <= nDoneW + 1;
    if (enB) begin
      if (nWrB < 512) begin
        logDataB[nWrB] <= dB;
        logCycB[nWrB]  <= cyc;
      end
      if (!wenB) nBadWenB <= nBadWenB + 1;
      nWrB <= nWrB + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0;
    inValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives one beat for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    inValid = 1'b1;
    p0 = a; p1 = b; p2 = c; p3 = d;
    tick();
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    nCompared++;
    if ({enA, wenA, addrA, dA, busyA, doneA, ovfA} !== 28'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs_A: got %0h expected 0", {enA, wenA, addrA, dA, busyA, doneA, ovfA});
    end
    nCompared++;
    if ({enW, wenW, addrW, dW, busyW, doneW, ovfW} !== 28'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs_W: got %0h expected 0", {enW, wenW, addrW, dW, busyW, doneW, ovfW});
    end
    nCompared++;
    if ({enB, wenB, addrB, dB, busyB, doneB, ovfB} !== 28'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs_B: got %0h expected 0", {enB, wenB, addrB, dB, busyB, doneB, ovfB});
    end
`ifdef CONV_RESULT_CHECKSUM_EN
    nCompared++;
    if ({ckA, ckW, ckB} !== 48'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_checksum: got %0h expected 0", {ckA, ckW, ckB});
    end
`endif
  endtask

  task automatic test_basic();
    int base, dBase, acc;
    doReset();
    pulseStart();
    base = nWrA;
    dBase = nDoneA;
    applyStimulus(8'h01, 8'h02, 8'h03, 8'h04);
    acc = cyc;
    nCompared++;
    if (busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy_high: got %0b expected 1", busyA);
    end
    repeat (3) tick();
    applyStimulus(8'h05, 8'h06, 8'h07, 8'h08);
    repeat (12) tick();
    nCompared++;
    if (nWrA - base !== 8) begin
      nMismatched++;
      $display("[TB] FAIL basic_write_count: got %0d expected 8", nWrA - base);
    end
    for (int i = 0; i < 8; i++) begin
      nCompared++;
      if (logAddrA[base + i] !== 15'(i) || logDataA[base + i] !== 8'(i + 1)) begin
        nMismatched++;
        $display("[TB] FAIL basic_write%0d: got addr %0d data %0h expected addr %0d data %0h",
                 i, logAddrA[base + i], logDataA[base + i], i, i + 1);
      end
    end
    nCompared++;
    if (logCycA[base] !== acc || logCycA[base + 3] !== acc + 3 || logCycA[base + 7] !== acc + 7) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got cycles %0d/%0d/%0d expected %0d/%0d/%0d",
               logCycA[base], logCycA[base + 3], logCycA[base + 7], acc, acc + 3, acc + 7);
    end
    nCompared++;
    if (nDoneA - dBase !== 1 || lastDoneCycA !== acc + 8) begin
      nMismatched++;
      $display("[TB] FAIL basic_done: got %0d pulses at cycle %0d expected 1 at %0d",
               nDoneA - dBase, lastDoneCycA, acc + 8);
    end
    nCompared++;
    if ({busyA, ovfA} !== 2'b00 || nBadWenA !== 0) begin
      nMismatched++;
      $display("[TB] FAIL basic_status: got busy %0b ovf %0b badwen %0d expected 0 0 0", busyA, ovfA, nBadWenA);
    end
`ifdef CONV_RESULT_CHECKSUM_EN
    nCompared++;
    if (ckA !== 16'h0024) begin
      nMismatched++;
      $display("[TB] FAIL basic_checksum: got %0h expected 24", ckA);
    end
`endif
  endtask

  task automatic test_idle_valid();
    int base;
    doReset();
    base = nWrA;
    inValid = 1'b1;
    p0 = 8'h5A; p1 = 8'h5B; p2 = 8'h5C; p3 = 8'h5D;
    repeat (6) tick();
    inValid = 1'b0;
    repeat (3) tick();
    nCompared++;
    if (nWrA !== base || busyA !== 1'b0 || ovfA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_valid: got writes %0d busy %0b ovf %0b expected 0 0 0", nWrA - base, busyA, ovfA);
    end
  endtask

  task automatic test_back_to_back();
    int base, acc, bad;
    doReset();
    pulseStart();
    base = nWrB;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'hAA, 8'hAA, 8'hAA, 8'hAA);
      if (i == 0) acc = cyc;
    end
    nCompared++;
    if (ovfB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL burst5_overflow: got %0b expected 0", ovfB);
    end
    applyStimulus(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    nCompared++;
    if (ovfB !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL burst6_overflow: got %0b expected 1", ovfB);
    end
    repeat (25) tick();
    nCompared++;
    if (nWrB - base !== 20) begin
      nMismatched++;
      $display("[TB] FAIL burst_write_count: got %0d expected 20", nWrB - base);
    end
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (logCycB[base + i] !== acc + i || logDataB[base + i] !== 8'hAA) bad++;
    nCompared++;
    if (bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL burst_gapfree: got %0d bad writes expected 0", bad);
    end
    nCompared++;
    if (busyB !== 1'b1 || ovfB !== 1'b1 || nBadWenB !== 0) begin
      nMismatched++;
      $display("[TB] FAIL burst_status: got busy %0b ovf %0b badwen %0d expected 1 1 0", busyB, ovfB, nBadWenB);
    end
  endtask

  task automatic test_drain_extra();
    int base, dBase;
    doReset();
    pulseStart();
    base = nWrA;
    dBase = nDoneA;
    applyStimulus(8'h10, 8'h11, 8'h12, 8'h13);
    applyStimulus(8'h14, 8'h15, 8'h16, 8'h17);
    applyStimulus(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    tick();
    applyStimulus(8'hEF, 8'hEF, 8'hEF, 8'hEF);
    repeat (14) tick();
    nCompared++;
    if (nWrA - base !== 8 || ovfA !== 1'b0 || nDoneA - dBase !== 1) begin
      nMismatched++;
      $display("[TB] FAIL drain_extra: got writes %0d ovf %0b done %0d expected 8 0 1",
               nWrA - base, ovfA, nDoneA - dBase);
    end
    nCompared++;
    if (logAddrA[base + 7] !== 15'd7 || logDataA[base + 7] !== 8'h17) begin
      nMismatched++;
      $display("[TB] FAIL drain_last_write: got addr %0d data %0h expected 7 17", logAddrA[base + 7], logDataA[base + 7]);
    end
  endtask

  task automatic test_wrap();
    int base, dBase, bad;
    doReset();
    pulseStart();
    base = nWrW;
    dBase = nDoneW;
    applyStimulus(8'h21, 8'h22, 8'h23, 8'h24);
    repeat (3) tick();
    applyStimulus(8'h25, 8'h26, 8'h27, 8'h28);
    repeat (12) tick();
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (logAddrW[base + i] !== 15'((32764 + i) % 32768) || logDataW[base + i] !== 8'(8'h21 + i)) bad++;
    nCompared++;
    if (nWrW - base !== 8 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_addresses: got %0d writes %0d bad expected 8 writes 0 bad", nWrW - base, bad);
    end
    nCompared++;
    if (nDoneW - dBase !== 1 || ovfW !== 1'b0 || busyW !== 1'b0 || nBadWenW !== 0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_done: got done %0d ovf %0b busy %0b badwen %0d expected 1 0 0 0",
               nDoneW - dBase, ovfW, busyW, nBadWenW);
    end
  endtask

  task automatic test_reset_midframe();
    int base, dBase, bad;
    doReset();
    pulseStart();
    base = nWrA;
    applyStimulus(8'h31, 8'h32, 8'h33, 8'h34);
    tick();
    tick();
    @(negedge clk);
    #1;
    nCompared++;
    if (nWrA - base !== 3 || addrA !== 15'd2 || dA !== 8'h33) begin
      nMismatched++;
      $display("[TB] FAIL midframe_before: got writes %0d addr %0d data %0h expected 3 2 33", nWrA - base, addrA, dA);
    end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({enA, wenA, addrA, dA, busyA, doneA, ovfA} !== 28'd0) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reset: got %0h expected 0", {enA, wenA, addrA, dA, busyA, doneA, ovfA});
    end
    #1;
    rst_n = 1'b1;
    tick();
    pulseStart();
    base = nWrA;
    dBase = nDoneA;
    applyStimulus(8'h41, 8'h42, 8'h43, 8'h44);
    repeat (3) tick();
    applyStimulus(8'h45, 8'h46, 8'h47, 8'h48);
    repeat (12) tick();
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (logAddrA[base + i] !== 15'(i) || logDataA[base + i] !== 8'(8'h41 + i)) bad++;
    nCompared++;
    if (nWrA - base !== 8 || bad !== 0 || nDoneA - dBase !== 1) begin
      nMismatched++;
      $display("[TB] FAIL midframe_restart: got writes %0d bad %0d done %0d expected 8 0 1",
               nWrA - base, bad, nDoneA - dBase);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_valid();
    test_back_to_back();
    test_drain_extra();
    test_wrap();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
- Receiving end of the filter's output stream (out_valid plus four 8-bit result lanes per beat).
- Buffers incoming beats in a small FIFO and serialises them into one 32768x8 result SRAM, one byte per cycle, at consecutive addresses.
- Counts a full frame, then signals done.
- Sits between the convolution filter outputs and the result SRAM that the bench dumps to BMP.

Parameters:
- NUM_PIXELS, 16384, pixels per frame; must be a multiple of 4 and at most 32768.
- BASE_ADDR, 0, first SRAM address written.
- FIFO_DEPTH, 4, beats buffered; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle arm pulse; accepted only in IDLE.
- in_valid  input  1  beat strobe from the filter.
- in_pixel0  input  8  lane 0, written first.
- in_pixel1  input  8  lane 1.
- in_pixel2  input  8  lane 2.
- in_pixel3  input  8  lane 3, written last.
- sram_en  output  1  SRAM enable, active high.
- sram_wen  output  1  SRAM write enable, 1 = write.
- sram_addr  output  15  SRAM address.
- sram_d  output  8  SRAM write data.
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse when the frame is fully written.
- overflow  output  1  sticky; a beat was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): every output is 0, FIFO is empty, counters are 0, state is IDLE. Reset mid-frame abandons the frame; the next start begins again at BASE_ADDR.
- All outputs are registered.
- States:
  - IDLE: start clears beat and pixel counters and overflow, then goes to COLLECT. in_valid is ignored in IDLE.
  - COLLECT: beats are accepted and written. When accepted beats reach NUM_PIXELS/4, go to DRAIN.
  - DRAIN: further in_valid is ignored and does not set overflow. When the last pixel is written, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Push rule: in COLLECT, in_valid=1 with FIFO not full pushes {p3,p2,p1,p0}.
  - If the FIFO is full and a pop happens the same cycle, the push is accepted.
  - Otherwise the beat is dropped and overflow is set; overflow stays set until the next accepted start or reset.
- Serialiser: a 2-bit lane counter. When idle with the FIFO non-empty, it pops one entry and issues writes of lane 0,1,2,3 on four consecutive cycles.
  - Each write cycle: sram_en=1, sram_wen=1, sram_d=lane, sram_addr=(BASE_ADDR+pixel_count) mod 32768.
  - pixel_count then increments.
  - The serialiser may pop the next entry in the same cycle lane 3 is issued, so back-to-back beats give gap-free writes.
- Latency: a beat accepted at cycle t into an empty FIFO with an idle serialiser drives lane 0 on the SRAM port at t+1 and lane 3 at t+4.
- Throughput: sustained 1 beat per 4 cycles. Faster bursts are absorbed up to FIFO_DEPTH beats.
- When not writing: sram_en=0, sram_wen=0, and sram_addr/sram_d hold their last values.
- done is asserted the cycle after the final write (pixel NUM_PIXELS-1); busy falls in that same cycle.
- Address wrap: if BASE_ADDR+NUM_PIXELS exceeds 32768, addresses wrap modulo 32768 without error.

Optional Feature:
- Macro: CONV_RESULT_CHECKSUM_EN.
- When defined:
  - Extra output port checksum, 16 bits: running sum modulo 65536 of every byte written this frame.
  - Cleared on accepted start and on reset; updated in the cycle each write is issued.
  - Final value is stable from the done pulse until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with NUM_PIXELS=8 and two beats {0x01,0x02,0x03,0x04} and {0x05..0x08} spaced 4 cycles apart: addresses 0..7 receive 0x01..0x08, done pulses once, overflow=0. With CONV_RESULT_CHECKSUM_EN, checksum=0x0024.
- Burst of 5 beats on consecutive cycles with FIFO_DEPTH=4, all data 0xAA: writes are gap-free and overflow=0 (pop on lane 3 makes room). A 6th consecutive beat is dropped and overflow=1.
- in_valid asserted while in IDLE with no start: no SRAM writes, busy=0.
- Extra beat after the final accepted beat (DRAIN): ignored, overflow stays 0, total writes = NUM_PIXELS.
- BASE_ADDR=32764, NUM_PIXELS=8: addresses 32764..32767, then 0..3.
- rst_n pulled low after 3 of 8 pixels: outputs go to 0 immediately. A new start then writes from BASE_ADDR again and done occurs after a full 8 pixels.
